// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apu_pkg
//  Brief    : Shared types and lookup functions for the APU frame sequencer.
//  Revision : 1.0
// ============================================================================
package apu_pkg;

   typedef enum logic [2:0] {
      STEP0 = 3'd0,
      STEP1 = 3'd1,
      STEP2 = 3'd2,
      STEP3 = 3'd3,
      STEP4 = 3'd4
   } step_t;

   typedef struct packed {
      logic quarter;
      logic half;
      logic irq;
   } step_act_t;

   function automatic int calc_prescale(input int clkrate, input int tick_hz);
      return clkrate / tick_hz;
   endfunction

   // Counter width; a prescale of 2 still needs one bit.
   function automatic int calc_ps_w(input int prescale);
      return (prescale > 2) ? $clog2(prescale) : 1;
   endfunction

   function automatic step_act_t step_action(input logic mode5, input step_t s);
      step_act_t a;
      a = '0;
      case (s)
         STEP0: a.quarter = 1'b1;
         STEP1: begin a.quarter = 1'b1; a.half = 1'b1; end
         STEP2: a.quarter = 1'b1;
         STEP3: if (!mode5) begin a.quarter = 1'b1; a.half = 1'b1; a.irq = 1'b1; end
         STEP4: if (mode5) begin a.quarter = 1'b1; a.half = 1'b1; end
         default: a = '0;
      endcase
      return a;
   endfunction

   function automatic step_t step_advance(input logic mode5, input step_t s);
      step_t n;
      case (s)
         STEP0:   n = STEP1;
         STEP1:   n = STEP2;
         STEP2:   n = STEP3;
         STEP3:   n = mode5 ? STEP4 : STEP0;
         default: n = STEP0;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prescale_tick.sv
`default_nettype none
// ============================================================================
//  Module   : prescale_tick
//  Brief    : Reloadable down-counter issuing a one-cycle tick at zero.
//  Revision : 1.0
// ============================================================================
module prescale_tick #(
   parameter int PRESCALE = 10,
   parameter int PS_W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick
);

   localparam logic [PS_W-1:0] c_reload = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] r_count;

   assign tick = (r_count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= c_reload;
      end else if (load || tick) begin
         r_count <= c_reload;
      end else begin
         r_count <= r_count - PS_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : apu_frame_sequencer
//  Brief    : APU frame sequencer: quarter/half/video-frame enables, 4/5-step
//             modes and frame IRQ controlled by the $4017 write.
//  Revision : 1.0
// ============================================================================
module apu_frame_sequencer
   import apu_pkg::*;
#(
   parameter int CLKRATE = 1_790_000,
   parameter int TICK_HZ = 240
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_we,
   input  logic       cfg_mode5,
   input  logic       cfg_irq_inhibit,
   input  logic       irq_ack,
   output logic       enable_quarter,
   output logic       enable_half,
   output logic       enable_frame,
   output logic       frame_irq,
   output logic [2:0] step
);

   // PRESCALE must be >= 2 for the tick to be a single-cycle event.
   localparam int PRESCALE = calc_prescale(CLKRATE, TICK_HZ);
   localparam int PS_W     = calc_ps_w(PRESCALE);

   logic      w_tick;
   step_t     r_step,    w_step_nxt;
   logic      r_mode5,   w_mode5_nxt;
   logic      r_inhibit, w_inhibit_nxt;
   logic [1:0] r_vdiv,   w_vdiv_nxt;
   logic      r_quarter, w_quarter_nxt;
   logic      r_half,    w_half_nxt;
   logic      r_frame,   w_frame_nxt;
   logic      r_irq,     w_irq_nxt;
   step_act_t w_act;

   prescale_tick #(
      .PRESCALE (PRESCALE),
      .PS_W     (PS_W)
   ) u_prescale (
      .clk  (clk),
      .rst  (rst),
      .load (cfg_we),
      .tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_step    <= STEP0;
         r_mode5   <= 1'b0;
         r_inhibit <= 1'b0;
         r_vdiv    <= 2'd0;
         r_quarter <= 1'b0;
         r_half    <= 1'b0;
         r_frame   <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_step    <= w_step_nxt;
         r_mode5   <= w_mode5_nxt;
         r_inhibit <= w_inhibit_nxt;
         r_vdiv    <= w_vdiv_nxt;
         r_quarter <= w_quarter_nxt;
         r_half    <= w_half_nxt;
         r_frame   <= w_frame_nxt;
         r_irq     <= w_irq_nxt;
      end
   end

   always_comb begin
      w_act         = step_action(r_mode5, r_step);
      w_step_nxt    = r_step;
      w_mode5_nxt   = r_mode5;
      w_inhibit_nxt = r_inhibit;
      w_vdiv_nxt    = w_tick ? r_vdiv + 2'd1 : r_vdiv;
      w_frame_nxt   = w_tick && (r_vdiv == 2'd0);
      w_quarter_nxt = 1'b0;
      w_half_nxt    = 1'b0;
      w_irq_nxt     = r_irq;

      if (cfg_we) begin
         // The write restarts the sequence and swallows a coincident tick.
         w_mode5_nxt   = cfg_mode5;
         w_inhibit_nxt = cfg_irq_inhibit;
         w_step_nxt    = STEP0;
         w_quarter_nxt = cfg_mode5;
         w_half_nxt    = cfg_mode5;
         if (cfg_irq_inhibit || irq_ack) begin
            w_irq_nxt = 1'b0;
         end
      end else begin
         if (w_tick) begin
            w_quarter_nxt = w_act.quarter;
            w_half_nxt    = w_act.half;
            w_step_nxt    = step_advance(r_mode5, r_step);
         end
         if (w_tick && w_act.irq && !r_inhibit) begin
            w_irq_nxt = 1'b1;
         end else if (irq_ack || r_inhibit) begin
            w_irq_nxt = 1'b0;
         end
      end
   end

   assign enable_quarter = r_quarter;
   assign enable_half    = r_half;
   assign enable_frame   = r_frame;
   assign frame_irq      = r_irq;
   assign step           = r_step;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apu_frame_sequencer
//  Brief    : Self-checking bench for apu_frame_sequencer (PRESCALE = 10).
//  Revision : 1.0
// ============================================================================
module tb_apu_frame_sequencer;

   localparam int PRESCALE = 10;

   logic       clk;
   logic       rst;
   logic       cfg_we;
   logic       cfg_mode5;
   logic       cfg_irq_inhibit;
   logic       irq_ack;
   logic       enable_quarter;
   logic       enable_half;
   logic       enable_frame;
   logic       frame_irq;
   logic [2:0] step;

   apu_frame_sequencer #(
      .CLKRATE (2400),
      .TICK_HZ (240)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_we          (cfg_we),
      .cfg_mode5       (cfg_mode5),
      .cfg_irq_inhibit (cfg_irq_inhibit),
      .irq_ack         (irq_ack),
      .enable_quarter  (enable_quarter),
      .enable_half     (enable_half),
      .enable_frame    (enable_frame),
      .frame_irq       (frame_irq),
      .step            (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] cycles;
      logic       we, m5, inh, ack;
      logic       q, h, f, irq;
      logic [2:0] stp;
   } vec_t;

   vec_t tab[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state: integer countdown, step index and frame divider.
   int  m_cnt, m_step, m_vdiv;
   bit  m_mode5, m_inh;
   bit  e_q, e_h, e_f, e_irq;
   bit  q_tab [2][5];
   bit  h_tab [2][5];

   function automatic vec_t mk(input int cyc, input bit we, m5, inh, ack,
                               input bit q, h, f, irq, input int stp);
      vec_t v;
      v.cycles = 8'(cyc);
      v.we = we; v.m5 = m5; v.inh = inh; v.ack = ack;
      v.q = q; v.h = h; v.f = f; v.irq = irq;
      v.stp = 3'(stp);
      return v;
   endfunction

   task automatic model_step(input bit r_i, we, m5, inh, ack);
      bit tick, sets;
      if (r_i) begin
         m_cnt = PRESCALE - 1; m_step = 0; m_vdiv = 0;
         m_mode5 = 0; m_inh = 0;
         e_q = 0; e_h = 0; e_f = 0; e_irq = 0;
         return;
      end
      tick  = (m_cnt == 0);
      e_f   = tick && (m_vdiv == 0);
      if (tick) m_vdiv = (m_vdiv + 1) % 4;
      m_cnt = (tick || we) ? PRESCALE - 1 : m_cnt - 1;
      e_q = 0; e_h = 0;
      if (we) begin
         m_mode5 = m5; m_inh = inh; m_step = 0;
         e_q = m5; e_h = m5;
         if (inh || ack) e_irq = 0;
      end else begin
         sets = tick && !m_mode5 && (m_step == 3) && !m_inh;
         if (tick) begin
            e_q    = q_tab[int'(m_mode5)][m_step];
            e_h    = h_tab[int'(m_mode5)][m_step];
            m_step = (m_step + 1) % (m_mode5 ? 5 : 4);
         end
         if (sets) e_irq = 1;
         else if (ack || m_inh) e_irq = 0;
      end
   endtask

   task automatic cyc(input bit r_i, we, m5, inh, ack);
      rst = r_i; cfg_we = we; cfg_mode5 = m5; cfg_irq_inhibit = inh; irq_ack = ack;
      @(posedge clk);
      model_step(r_i, we, m5, inh, ack);
      @(negedge clk);
      rst = 0; cfg_we = 0; cfg_mode5 = 0; cfg_irq_inhibit = 0; irq_ack = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic check(input string name, input logic [6:0] exp);
      logic [6:0] act;
      act = {enable_quarter, enable_half, enable_frame, frame_irq, step};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: q/h/f/irq/step got %b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                  name, act[6], act[5], act[4], act[3], act[2:0],
                  exp[6], exp[5], exp[4], exp[3], exp[2:0]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      q_tab = '{'{1, 1, 1, 1, 0}, '{1, 1, 1, 0, 1}};
      h_tab = '{'{0, 1, 0, 1, 0}, '{0, 1, 0, 0, 1}};
      rst = 1; cfg_we = 0; cfg_mode5 = 0; cfg_irq_inhibit = 0; irq_ack = 0;

      //              cyc we m5 in ak  q h f i step
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 1, 0, 0, 2));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 0, 0, 3));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 1, 0, 1, 0));
      tab.push_back(mk( 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk( 9, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      tab.push_back(mk(30, 0, 0, 0, 0, 1, 1, 0, 1, 0));
      tab.push_back(mk( 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(39, 0, 0, 0, 1, 1, 1, 0, 1, 0));
      tab.push_back(mk( 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      tab.push_back(mk(30, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      tab.push_back(mk( 1, 1, 1, 0, 0, 1, 1, 0, 0, 0));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 1, 0, 0, 2));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 0, 0, 3));
      tab.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      tab.push_back(mk(10, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 0, 0, 1));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 1, 0, 0, 2));
      tab.push_back(mk(10, 0, 0, 0, 0, 1, 0, 1, 0, 3));
      tab.push_back(mk(10, 1, 0, 1, 0, 0, 0, 0, 0, 0));

      @(negedge clk);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("reset", 7'b0000_000);

      foreach (tab[i]) begin
         for (int c = 0; c < int'(tab[i].cycles); c++) begin
            if (c == int'(tab[i].cycles) - 1)
               cyc(0, tab[i].we, tab[i].m5, tab[i].inh, tab[i].ack);
            else
               cyc(0, 0, 0, 0, 0);
         end
         check($sformatf("vec%0d", i),
               {tab[i].q, tab[i].h, tab[i].f, tab[i].irq, tab[i].stp});
      end

      // Reset in mid-count: prescaler at 4, step 2.
      cyc(1, 0, 0, 0, 0);
      idle(25);
      check("midcount_pre", 7'b0000_010);
      cyc(1, 0, 0, 0, 0);
      check("midcount_rst", 7'b0000_000);
      idle(9);
      check("midcount_quiet", 7'b0000_000);
      idle(1);
      check("midcount_first", 7'b1010_001);

      // Reset landing on a tick cycle must not emit a pulse.
      cyc(1, 0, 0, 0, 0);
      idle(9);
      cyc(1, 0, 0, 0, 0);
      check("tick_rst", 7'b0000_000);
      idle(10);
      check("tick_rst_after", 7'b1010_001);

      // Randomised traffic against the reference model.
      cyc(1, 0, 0, 0, 0);
      for (int n = 0; n < 2000; n++) begin
         cyc(($urandom % 400) == 0,
             ($urandom % 40) == 0,
             $urandom % 2,
             ($urandom % 3) == 0,
             ($urandom % 15) == 0);
         check("rand", {e_q, e_h, e_f, e_irq, 3'(m_step)});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
Parametrised frame sequencer for the APU. It generates the quarter-frame, half-frame and video-frame clock enables from the system clock. It adds the NES 4-step/5-step sequencer modes, a frame IRQ with inhibit and acknowledge, and a register write that restarts the sequence. It sits between the CPU register interface ($4017 write) and the envelope, length-counter and sweep units.

Parameters:
CLKRATE, 1_790_000, system clock rate in Hz
TICK_HZ, 240, quarter-frame tick rate in Hz
PRESCALE, CLKRATE/TICK_HZ, clocks per sequencer step (derived localparam; must be >= 2)
PS_W, $clog2(PRESCALE), prescaler width (derived localparam)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cfg_we  input  1  single-cycle write strobe for mode/inhibit ($4017)
cfg_mode5  input  1  write data: 1 = 5-step mode, 0 = 4-step mode
cfg_irq_inhibit  input  1  write data: 1 = suppress and clear frame IRQ
irq_ack  input  1  single-cycle clear of frame IRQ (status read)
enable_quarter  output  1  one-cycle quarter-frame pulse (envelope, linear counter)
enable_half  output  1  one-cycle half-frame pulse (length counter, sweep)
enable_frame  output  1  one-cycle 60 Hz video-frame pulse (TICK_HZ/4)
frame_irq  output  1  frame IRQ flag, level
step  output  3  current sequencer step, 0..3 or 0..4

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - prescaler = PRESCALE-1, step = 0, vdiv = 0
  - mode = 4-step, inhibit = 0
  - enable_quarter = enable_half = enable_frame = frame_irq = 0
- Prescaler:
  - Decrements each clock.
  - At 0 it reloads PRESCALE-1 and asserts internal tick for that cycle.
- All enable outputs are registered, asserted the cycle after the tick, and high for exactly 1 clock.
- 4-step mode, on each tick, by step:
  - step 0: quarter
  - step 1: quarter + half
  - step 2: quarter
  - step 3: quarter + half; sets frame_irq if inhibit = 0
  - step then advances 3 -> 0.
- 5-step mode, on each tick, by step:
  - step 0: quarter
  - step 1: quarter + half
  - step 2: quarter
  - step 3: no pulse
  - step 4: quarter + half
  - step then advances 4 -> 0. frame_irq is never set.
- step output: registered and updated on the tick. It shows the step whose actions fire next.
- enable_frame:
  - Driven by a free-running 2-bit vdiv that increments on every tick.
  - Pulses when a tick occurs with vdiv == 0.
  - Unaffected by mode and by cfg_we; only rst clears vdiv.
- cfg_we:
  - Latches mode and inhibit.
  - Reloads prescaler to PRESCALE-1 and sets step = 0.
  - If cfg_mode5 = 1: enable_quarter and enable_half pulse on the next cycle (immediate clock).
  - If cfg_mode5 = 0: no pulse.
  - If cfg_irq_inhibit = 1: frame_irq clears on the next cycle.
- frame_irq:
  - Set when a step-3 tick occurs in 4-step mode with inhibit = 0.
  - Cleared by irq_ack, by inhibit = 1, or by rst. Holds otherwise.
- Simultaneous events:
  - cfg_we with a tick: the write wins; the tick's step actions and step advance are suppressed, but vdiv still advances.
  - irq_ack with an IRQ-setting tick: set wins; frame_irq = 1.
  - cfg_we with irq_inhibit = 1 and an IRQ-setting tick: the write wins; frame_irq = 0.
  - rst overrides everything.
- Mid-operation: rst asserted mid-count returns to the reset state on the next edge; no pulse is emitted that cycle.

Decomposition:
- Package apu_pkg:
  - step encodings and a step-action lookup (quarter/half/irq per step per mode) as constant functions
  - PRESCALE/PS_W derivation helper
- Sub-module prescale_tick: parametrised down-counter with reload and tick output. It is reusable by the DMC and noise timers.

Test Plan:
- Use CLKRATE=2400, TICK_HZ=240 (PRESCALE=10). Release rst -> the first enable_quarter 10 clocks after release (cycle 10), then every 10 clocks; enable_half on steps 1,3; frame_irq = 1 after the step-3 tick (cycle 40); enable_frame every 40 clocks.
- 4-step, frame_irq set; pulse irq_ack -> frame_irq = 0 next cycle, set again 40 clocks later. Write inhibit = 1 -> no IRQ over 200 clocks.
- cfg_we with cfg_mode5 = 1 -> quarter + half pulse on the next cycle; then over 50 clocks: quarter at steps 0,1,2,4, none at step 3, half at steps 1,4; frame_irq stays 0.
- cfg_we on the exact tick cycle -> no step pulse that cycle, step = 0, next tick 10 clocks after the write; enable_frame cadence unchanged.
- irq_ack coincident with the step-3 tick -> frame_irq = 1. rst asserted mid-count (prescaler = 4, step = 2) -> all outputs 0, step = 0, prescaler restarts at 9.
